// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared types for the instruction-fetch stage: fetch FSM state encoding,
// the fetch FIFO entry layout and the default reset PC.
// Optional feature macro: INST_FETCH_ADEL_EN adds the address-error (adel)
// field to each FIFO entry.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hbfc00000;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ADDR = 2'd1,
    S_WAIT_DATA = 2'd2,
    S_CANCEL    = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
`ifdef INST_FETCH_ADEL_EN
    logic        adel;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small circular buffer holding fetched {pc, inst[, adel]} entries.
// Ports:
//   clk, rst   clock, synchronous active-high reset (all slots <= RESET_VAL)
//   i_push     write i_din at the tail
//   i_pop      drop the head (ignored when empty)
//   i_clear    empty the buffer; overrides push and pop in the same edge
//   i_din      entry to write
//   o_count    number of valid entries
//   o_head     entry at the head (stale contents when o_count == 0)
// The caller guarantees no push while full.
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int             DEPTH     = 2,
  parameter int             W         = 64,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [W-1:0]             i_din,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [W-1:0]             o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign w_pop   = i_pop & (r_count != '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Instruction-fetch stage between the pc register and an SRAM-like
// req/addr_ok/data_ok instruction bus. Keeps at most one request in flight,
// drops responses made stale by flush, and buffers fetched words with their
// PCs in fetch_fifo, which feeds decode through a valid/ready handshake.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pc_addr, pc_valid, pc_ready   fetch address from pc; pc_ready = accepted
//   flush                         discard buffered and in-flight fetches
//   inst_req, inst_addr           bus request / address
//   inst_addr_ok, inst_data_ok    bus address accept / data return
//   inst_rdata                    returned instruction word
//   id_valid, id_ready            decode handshake on the FIFO head
//   id_pc, id_inst, id_adel       head entry fields
// Optional feature macro: INST_FETCH_ADEL_EN -- misaligned fetch addresses
// are not sent to the bus; an entry flagged id_adel=1 is queued instead.
// -----------------------------------------------------------------------------
module inst_fetch_ctrl
  import inst_fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef INST_FETCH_ADEL_EN
  localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, inst: 32'h0, adel: 1'b0};
`else
  localparam fetch_entry_t RESET_ENTRY = '{pc: RESET_PC, inst: 32'h0};
`endif

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_req_pc, w_req_pc_nxt;
  logic         r_kill, w_kill_nxt;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic          w_credit;
  logic          w_misaligned;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // A word still owed by the bus reserves a FIFO slot.
  assign w_inflight = {1'b0, w_count} + {{CW{1'b0}}, (r_state == S_WAIT_DATA)};
  assign w_credit   = w_inflight < (CW+1)'(DEPTH);

`ifdef INST_FETCH_ADEL_EN
  assign w_misaligned = pc_valid & (pc_addr[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_req_pc_nxt      = r_req_pc;
    w_kill_nxt        = r_kill;
    inst_req          = 1'b0;
    inst_addr         = r_req_pc;
    pc_ready          = 1'b0;
    w_push            = 1'b0;
    w_push_entry      = RESET_ENTRY;
    w_push_entry.pc   = r_req_pc;
    w_push_entry.inst = inst_rdata;

    case (r_state)
      S_IDLE: begin
        inst_addr = pc_addr;
        inst_req  = pc_valid & w_credit & ~flush & ~w_misaligned;
        if (inst_req) begin
          w_req_pc_nxt = pc_addr;
          if (inst_addr_ok) begin
            w_state_nxt = S_WAIT_DATA;
            pc_ready    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_ADDR;
            w_kill_nxt  = 1'b0;
          end
        end
`ifdef INST_FETCH_ADEL_EN
        else if (w_misaligned & w_credit & ~flush) begin
          // Misaligned fetch never reaches the bus; queue an error entry.
          w_push            = 1'b1;
          pc_ready          = 1'b1;
          w_push_entry.pc   = pc_addr;
          w_push_entry.inst = 32'h0;
          w_push_entry.adel = 1'b1;
        end
`endif
      end

      S_WAIT_ADDR: begin
        // Address must stay on the bus until accepted, even across flush;
        // kill remembers that the eventual response is stale.
        inst_req = 1'b1;
        if (flush) w_kill_nxt = 1'b1;
        if (inst_addr_ok) begin
          pc_ready    = ~flush & ~r_kill;
          w_state_nxt = (flush | r_kill) ? S_CANCEL : S_WAIT_DATA;
          w_kill_nxt  = 1'b0;
        end
      end

      S_WAIT_DATA: begin
        if (inst_data_ok) begin
          w_push      = ~flush;
          w_state_nxt = S_IDLE;
        end else if (flush) begin
          w_state_nxt = S_CANCEL;
        end
      end

      S_CANCEL: begin
        if (inst_data_ok) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    if (rst) begin
      inst_req  = 1'b0;
      inst_addr = 32'h0;
      pc_ready  = 1'b0;
      w_push    = 1'b0;
    end
  end

  // ---- state register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_req_pc <= w_req_pc_nxt;
  end

  // ---- fetch buffer stage ----
  assign w_pop = id_valid & id_ready;

  fetch_fifo #(
    .DEPTH     (DEPTH),
    .W         ($bits(fetch_entry_t)),
    .RESET_VAL (RESET_ENTRY)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_din   (w_push_entry),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign id_valid = (w_count != '0);
  assign id_pc    = w_head.pc;
  assign id_inst  = w_head.inst;
`ifdef INST_FETCH_ADEL_EN
  assign id_adel  = w_head.adel;
`else
  assign id_adel  = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  always #5 clk = ~clk;

  inst_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_addr      (pc_addr),
    .pc_valid     (pc_valid),
    .pc_ready     (pc_ready),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst),
    .id_adel      (id_adel)
  );

  // Transaction-level reference: words waiting for decode, and bus
  // transactions whose data is still owed (live = result must be kept).
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adel; } ent_t;
  typedef struct { logic [31:0] addr; bit live; } bus_t;

  ent_t        buf_q[$];
  bus_t        bus_q[$];
  bit          held;
  bit          held_flush;
  logic [31:0] held_addr;
  bit          rst_prev = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          rdy_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h9bc20001;
  endfunction

  // Sample at the falling edge, compare, then advance the reference model
  // to what the next rising edge must produce.
  task automatic step();
    bit          exp_req, exp_rdy, mis, live, credit, adel_push;
    logic [31:0] exp_addr;
    bus_t        b;
    ent_t        e;
    @(negedge clk);
    if (rst) begin
      chk("rst_inst_req", inst_req, 0);
      chk("rst_pc_ready", pc_ready, 0);
      chk("rst_inst_addr", inst_addr, 0);
      if (rst_prev) begin
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_pc", id_pc, RESET_PC);
        chk("rst_id_inst", id_inst, 0);
        chk("rst_id_adel", id_adel, 0);
      end
      buf_q.delete();
      bus_q.delete();
      held = 0;
      held_flush = 0;
    end else begin
      mis = 0;
`ifdef INST_FETCH_ADEL_EN
      mis = pc_valid && (pc_addr[1:0] != 2'b00);
`endif
      credit    = buf_q.size() < DEPTH;
      adel_push = 0;
      exp_addr  = pc_addr;
      if (held) begin
        exp_req  = 1;
        exp_addr = held_addr;
      end else if (bus_q.size() != 0) begin
        exp_req = 0;
      end else begin
        exp_req   = pc_valid && credit && !flush && !mis;
        adel_push = pc_valid && credit && !flush && mis;
      end
      live    = !flush && !(held && held_flush);
      exp_rdy = (exp_req && inst_addr_ok && live) || adel_push;

      chk("inst_req", inst_req, exp_req);
      if (exp_req) chk("inst_addr", inst_addr, exp_addr);
      chk("pc_ready", pc_ready, exp_rdy);
      chk("id_valid", id_valid, buf_q.size() != 0);
      if (buf_q.size() != 0) begin
        chk("id_pc", id_pc, buf_q[0].pc);
        chk("id_inst", id_inst, buf_q[0].inst);
        chk("id_adel", id_adel, buf_q[0].adel);
      end
      if (pc_ready) rdy_cnt++;

      if (id_ready && buf_q.size() != 0) void'(buf_q.pop_front());
      if (inst_data_ok && bus_q.size() != 0) begin
        b = bus_q.pop_front();
        if (b.live && !flush) begin
          e.pc = b.addr; e.inst = mem_word(b.addr); e.adel = 0;
          buf_q.push_back(e);
        end
      end
      if (flush) foreach (bus_q[i]) bus_q[i].live = 0;
      if (exp_req && inst_addr_ok) begin
        b.addr = exp_addr; b.live = live;
        bus_q.push_back(b);
        held = 0;
        held_flush = 0;
      end else if (exp_req) begin
        if (!held) begin
          held = 1; held_addr = pc_addr; held_flush = 0;
        end
        if (flush) held_flush = 1;
      end
      if (adel_push) begin
        e.pc = pc_addr; e.inst = 32'h0; e.adel = 1;
        buf_q.push_back(e);
      end
      if (flush) buf_q.delete();
    end
    rst_prev = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit pv, input logic [31:0] pa, input bit aok,
                     input bit dok, input bit fl, input bit rdy);
    pc_valid = pv; pc_addr = pa; inst_addr_ok = aok;
    inst_data_ok = dok; flush = fl; id_ready = rdy;
    inst_rdata = (bus_q.size() != 0) ? mem_word(bus_q[0].addr) : 32'hdeadbeef;
    step();
  endtask

  initial begin
    rst = 1; pc_valid = 0; pc_addr = 0; flush = 0; inst_addr_ok = 0;
    inst_data_ok = 0; inst_rdata = 0; id_ready = 0;
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    rst = 0;

    // Single fetch: request+addr_ok, data next cycle, visible the cycle after.
    rdy_cnt = 0;
    cyc(1, 32'hbfc00000, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("single_valid", id_valid, 1);
    chk("single_pc", id_pc, 32'hbfc00000);
    chk("single_inst", id_inst, 32'h24020001);
    cyc(0, 0, 0, 0, 0, 1);
    chk("single_rdy_pulses", rdy_cnt, 1);

    // Held request while pc_addr wanders.
    cyc(1, 32'hbfc00010, 0, 0, 0, 1);
    cyc(1, 32'hbfc00020, 0, 0, 0, 1);
    cyc(1, 32'hbfc00030, 0, 0, 0, 1);
    chk("held_addr", inst_addr, 32'hbfc00010);
    cyc(1, 32'hbfc00040, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Backpressure: fill, stall, then drain and resume.
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++)
      cyc(1, 32'hbfc00000 + 32'(4 * rdy_cnt), 1, bus_q.size() != 0, 0, 0);
    chk("bp_full_valid", id_valid, 1);
    chk("bp_req_low", inst_req, 0);
    chk("bp_head", id_pc, 32'hbfc00000);
    chk("bp_accepts", rdy_cnt, 2);
    for (int i = 0; i < 8; i++)
      cyc(1, 32'hbfc00000 + 32'(4 * rdy_cnt), 1, bus_q.size() != 0, 0, 1);
    chk("bp_resumed", rdy_cnt >= 4, 1);
    repeat (4) cyc(0, 0, 0, bus_q.size() != 0, 0, 1);

    // Flush with one word buffered and one request outstanding.
    cyc(1, 32'hbfc00100, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 32'hbfc00104, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("fl_valid", id_valid, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("fl_drop", id_valid, 0);

    // Flush in the same cycle as data_ok; a new request follows at once.
    cyc(1, 32'hbfc00200, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0);
    chk("fc_drop", id_valid, 0);
    pc_valid = 1; pc_addr = 32'hbfc00300; inst_addr_ok = 0;
    inst_data_ok = 0; flush = 0; #1;
    chk("fc_newreq", inst_req, 1);
    step();
    cyc(1, 32'hbfc00300, 1, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // Reset while data is owed; the late data_ok must be ignored.
    cyc(1, 32'hbfc00400, 1, 0, 0, 0);
    rst = 1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst = 0;
    cyc(0, 0, 0, 1, 0, 0);
    chk("late_drop", id_valid, 0);

`ifdef INST_FETCH_ADEL_EN
    cyc(1, 32'hbfc00002, 1, 0, 0, 0);
    chk("adel_valid", id_valid, 1);
    chk("adel_flag", id_adel, 1);
    chk("adel_inst", id_inst, 0);
    chk("adel_pc", id_pc, 32'hbfc00002);
    cyc(0, 0, 0, 0, 0, 1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      bit          rdy;
      a = 32'hbfc00000 + 32'(4 * $urandom_range(0, 255));
`ifdef INST_FETCH_ADEL_EN
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
`endif
      rdy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 2);
      cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1,
          bus_q.size() != 0 && $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

- Instruction-fetch stage between the `pc` register and the instruction SRAM-like bus.
- Accepts the current fetch address from `pc` and issues it on a req/addr_ok/data_ok bus.
- Tracks one outstanding request and drops responses made stale by a redirect (`flush`).
- Buffers returned instructions with their PCs in a small FIFO, which feeds decode through a valid/ready handshake.

## Interface

Parameters:
- DEPTH, 2 — fetch FIFO entries (power of two, ≥2).
- RESET_PC, 32'hbfc00000 — value shown on `id_pc` and stored in every FIFO slot after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_addr  in  32  fetch address from `pc`.
- pc_valid  in  1  `pc_addr` valid (driven by pc's `inst_ce`).
- pc_ready  out  1  address accepted this cycle; `pc` may advance.
- flush  in  1  redirect/exception; discard all buffered and in-flight fetches.
- inst_req  out  1  bus request.
- inst_addr  out  32  bus address.
- inst_addr_ok  in  1  bus accepted address.
- inst_data_ok  in  1  bus returns data.
- inst_rdata  in  32  instruction word.
- id_valid  out  1  FIFO head valid.
- id_ready  in  1  decode consumes head.
- id_pc  out  32  head PC.
- id_inst  out  32  head instruction.
- id_adel  out  1  head carries a fetch address error.

## Operation

- **State machine:**
  - IDLE: no request outstanding.
  - WAIT_ADDR: request held, awaiting `inst_addr_ok`.
  - WAIT_DATA: one request accepted, awaiting `inst_data_ok`.
  - CANCEL: one request accepted and stale; its response is dropped.
- **Credit:** `credit = (count + (state==WAIT_DATA)) < DEPTH`.
- **IDLE:**
  - `inst_req = pc_valid & credit & !flush & !misaligned`, with `inst_addr = pc_addr`.
  - On `inst_addr_ok`: go to WAIT_DATA and latch `pc_addr` as `req_pc`.
  - Otherwise, if `inst_req` is high: latch `pc_addr` into `req_pc` and go to WAIT_ADDR.
- **WAIT_ADDR:**
  - `inst_req=1` and `inst_addr=req_pc`, held stable until `inst_addr_ok`, even across `flush`.
  - On `inst_addr_ok`: go to WAIT_DATA, or to CANCEL if `flush` is high now or was seen since entering WAIT_ADDR (tracked by a sticky `kill` bit).
- **WAIT_DATA:**
  - On `inst_data_ok & !flush`: push {`req_pc`, `inst_rdata`, 0} and go to IDLE.
  - On `inst_data_ok & flush`: drop the data and go to IDLE.
  - On `flush` without data: go to CANCEL.
- **CANCEL:** on `inst_data_ok`, drop the data and go to IDLE.
- **pc_ready:** `inst_req & inst_addr_ok & !flush & !kill`.
- **FIFO:**
  - Push and pop in the same cycle are allowed.
  - Credit guarantees a push never occurs when full.
  - `flush` clears `count` in the same edge, overriding push and pop.
- **Outputs:** `id_valid = (count!=0)`. `id_pc`/`id_inst`/`id_adel` show the head slot; values are don't-care-stable when `id_valid=0`.

## Timing

- **Reset values:** `pc_ready=0`, `inst_req=0`, `inst_addr=0`, `id_valid=0`, `id_pc=RESET_PC`, `id_inst=0`, `id_adel=0`, state IDLE, `count=0`, `kill=0`.
- **Minimum latency:** `pc_valid` plus same-cycle `addr_ok` in cycle N, `data_ok` in N+1, `id_valid` in N+2. There is no bypass path.
- **Throughput:** at most one outstanding request. With zero-wait memory, one instruction every 2 cycles.
- **Decode backpressure:** with `id_ready=0`, the FIFO fills to DEPTH, then `inst_req` stays low.
- **Mid-operation reset:** reset during WAIT_DATA/CANCEL returns to IDLE. A late `data_ok` arriving in IDLE is ignored.

## Configuration

- Macro: `INST_FETCH_ADEL_EN`.
- **Defined:**
  - When `pc_valid & pc_addr[1:0]!=0` in IDLE with credit: no bus request is issued.
  - The block pushes {`pc_addr`, 32'h0, 1} in that same cycle and asserts `pc_ready`.
- **Undefined:**
  - No alignment check; the misaligned term is constant 0.
  - `id_adel` is tied to 0 and the adel FIFO field is removed.

## Structure

- Package `inst_fetch_pkg` holds:
  - the state enum (IDLE, WAIT_ADDR, WAIT_DATA, CANCEL);
  - the FIFO entry struct {pc[31:0], inst[31:0], adel};
  - `RESET_PC` default.
- One sub-module: `fetch_fifo`.
  - Parameterised by DEPTH and entry width.
  - Ports: push, pop, clear, count, head.

## Test plan

- **Single fetch:** release reset. `pc_valid=1`, `pc_addr=bfc00000`, `addr_ok` same cycle, `data_ok` next cycle with `24020001`. Expect `id_valid` 2 cycles after the request with `id_pc=bfc00000`, `id_inst=24020001`, and exactly one `pc_ready` pulse.
- **Held request:** `addr_ok` delayed 3 cycles while `pc_addr` changes. Expect `inst_addr` held at the first value, `inst_req` continuously high, and `pc_ready` only in the `addr_ok` cycle.
- **Backpressure:** `id_ready=0`, DEPTH=2. Expect 2 entries (bfc00000, bfc00004), then `inst_req` low. Raise `id_ready`; expect entries pop in order and fetching resumes.
- **Flush in WAIT_DATA:** `flush` with one request outstanding and 1 entry buffered. Expect `id_valid=0` next cycle, and the later `data_ok` word not pushed.
- **Flush coincident:** `flush` in the same cycle as `data_ok`. Expect the word dropped, state IDLE, and a new request issued next cycle.
- **Alignment check (`INST_FETCH_ADEL_EN` defined):** `pc_addr=bfc00002`. Expect no `inst_req`, then an entry with `id_adel=1` and `id_inst=0`.
